// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Fetch FSM encoding, PC step, alignment mask and buffer entry layout.
package if_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DROP  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC      = 32'd4;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_ent_t;

  function automatic logic [31:0] inc_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word and its PC+4.
// Catches a transfer that lands while the stage is stalled.
module fetch_skid_buf
  import if_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  fetch_ent_t ent_q;
  logic       valid_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else if (load) begin
      valid_q     <= 1'b1;
      ent_q.instr <= instr_in;
      ent_q.pc4   <= pc4_in;
    end
  end

  assign valid = valid_q;
  assign instr = ent_q.instr;
  assign pc4   = ent_q.pc4;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ready port, IF/ID drive.
// FETCH_PERF_CNT_EN adds saturating fetched/bubble counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Redirect_valid,
  input  logic [31:0] Redirect_target,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ready,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] PCAdder_out,
  output logic [31:0] Instruction_out,
  output logic        IFID_flush,
  output logic        Fetch_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] Perf_fetched,
  output logic [31:0] Perf_bubbles
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, tgt_q;
  logic [31:0]  pc_inc, tgt_al;
  logic         req_q, xfer;
  logic         redir, stall_only, run;
  logic         drop_done, hold_go, fetch_go;
  logic         buf_load, buf_clear, buf_valid;
  logic [31:0]  buf_instr, buf_pc4;

  assign xfer       = req_q & Imem_ready;
  assign pc_inc     = inc_pc(pc_q);
  assign tgt_al     = Redirect_target & ALIGN_MASK;
  assign Imem_req   = req_q;
  assign Imem_addr  = pc_q;

  assign redir      = Redirect_valid;
  assign stall_only = !Redirect_valid & Stall;
  assign run        = !Redirect_valid & !Stall;

  assign drop_done  = (state_q == ST_DROP) & Imem_ready;
  assign hold_go    = (state_q == ST_HOLD) & buf_valid;
  assign fetch_go   = (state_q == ST_FETCH) & xfer;

  always_comb begin
    state_d   = state_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (Redirect_valid) begin
          state_d = (req_q && !Imem_ready) ? ST_DROP : ST_FETCH;
        end else if (xfer && Stall) begin
          state_d  = ST_HOLD;
          buf_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (Redirect_valid || !Stall) begin
          state_d   = ST_FETCH;
          buf_clear = 1'b1;
        end
      end
      ST_DROP: begin
        if (Imem_ready) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  fetch_skid_buf u_buf (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .instr_in (Imem_rdata),
    .pc4_in   (pc_inc),
    .valid    (buf_valid),
    .instr    (buf_instr),
    .pc4      (buf_pc4)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q         <= ST_FETCH;
      req_q           <= 1'b0;
      pc_q            <= RESET_PC;
      tgt_q           <= RESET_PC;
      PCAdder_out     <= '0;
      Instruction_out <= NOP_INSTR;
      IFID_flush      <= 1'b0;
      Fetch_valid     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= (state_d != ST_HOLD);
      IFID_flush <= Redirect_valid;
      unique case (1'b1)
        redir: begin
          Instruction_out <= NOP_INSTR;
          Fetch_valid     <= 1'b0;
          // old request still outstanding: park target until it drains
          if (state_d == ST_DROP) tgt_q <= tgt_al;
          else pc_q <= tgt_al;
        end
        stall_only: begin
          if (drop_done) pc_q <= tgt_q;
        end
        run: begin
          Instruction_out <= NOP_INSTR;
          Fetch_valid     <= 1'b0;
          if (drop_done) begin
            pc_q <= tgt_q;
          end else if (hold_go) begin
            Instruction_out <= buf_instr;
            PCAdder_out     <= buf_pc4;
            Fetch_valid     <= 1'b1;
            pc_q            <= pc_inc;
          end else if (fetch_go) begin
            Instruction_out <= Imem_rdata;
            PCAdder_out     <= pc_inc;
            Fetch_valid     <= 1'b1;
            pc_q            <= pc_inc;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Perf_fetched <= '0;
      Perf_bubbles <= '0;
    end else begin
      if (Fetch_valid && Perf_fetched != 32'hFFFF_FFFF)
        Perf_fetched <= Perf_fetched + 32'd1;
      if (!Fetch_valid && Perf_bubbles != 32'hFFFF_FFFF)
        Perf_bubbles <= Perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: waits, stalls, redirects, wrap.
// Expected words come from a local imem model keyed by bench-tracked PC.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall;
  logic        Redirect_valid;
  logic [31:0] Redirect_target;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_ready;
  logic [31:0] Imem_rdata;
  logic [31:0] PCAdder_out;
  logic [31:0] Instruction_out;
  logic        IFID_flush;
  logic        Fetch_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] Perf_fetched;
  logic [31:0] Perf_bubbles;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_pc;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return a ^ 32'h1357_9BDF;
  endfunction

  assign Imem_rdata = mem_word(Imem_addr);

  if_fetch_unit dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Stall           (Stall),
    .Redirect_valid  (Redirect_valid),
    .Redirect_target (Redirect_target),
    .Imem_req        (Imem_req),
    .Imem_addr       (Imem_addr),
    .Imem_ready      (Imem_ready),
    .Imem_rdata      (Imem_rdata),
    .PCAdder_out     (PCAdder_out),
    .Instruction_out (Instruction_out),
    .IFID_flush      (IFID_flush),
    .Fetch_valid     (Fetch_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Perf_fetched    (Perf_fetched),
    .Perf_bubbles    (Perf_bubbles)
`endif
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    Stall = 1'b0;
    Redirect_valid = 1'b0;
    Redirect_target = '0;
    Imem_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if ({Imem_req, Fetch_valid, IFID_flush, Instruction_out, PCAdder_out}
        !== {3'b000, NOP, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_vals got req=%b v=%b f=%b i=%h p=%h want 0 0 0 %h 0",
               Imem_req, Fetch_valid, IFID_flush, Instruction_out,
               PCAdder_out, NOP);
    end
    Rst = 1'b1;
    tick();
    vectors++;
    if ({Imem_req, Imem_addr} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL first_req got req=%b a=%h want 1 0", Imem_req, Imem_addr);
    end
    tick();
    #2 Rst = 1'b0;
    #1;
    vectors++;
    if ({Imem_req, Fetch_valid, Instruction_out} !== {2'b00, NOP}) begin
      miscompares++;
      $display("FAIL async_rst got req=%b v=%b i=%h want 0 0 %h",
               Imem_req, Fetch_valid, Instruction_out, NOP);
    end
    #2 Rst = 1'b1;
    tick();
    vectors++;
    if ({Imem_req, Imem_addr, Fetch_valid, Instruction_out}
        !== {1'b1, 32'h0, 1'b0, NOP}) begin
      miscompares++;
      $display("FAIL post_rst got req=%b a=%h v=%b i=%h want 1 0 0 %h",
               Imem_req, Imem_addr, Fetch_valid, Instruction_out, NOP);
    end
    exp_pc = 32'h0;
  endtask

  task automatic test_first_fetch();
    logic [63:0] e;
    Imem_ready = 1'b1;
    sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
    tick();
    Imem_ready = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({Fetch_valid, Instruction_out, PCAdder_out} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL first_fetch got v=%b i=%h p=%h want 1 %h %h",
               Fetch_valid, Instruction_out, PCAdder_out, e[63:32], e[31:0]);
    end
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_wait_states();
    logic [63:0] e;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({Imem_req, Imem_addr} !== {1'b1, exp_pc}) begin
        miscompares++;
        $display("FAIL wait_addr[%0d] got req=%b a=%h want 1 %h",
                 i, Imem_req, Imem_addr, exp_pc);
      end
      tick();
      vectors++;
      if ({Fetch_valid, Instruction_out, PCAdder_out}
          !== {1'b0, NOP, 32'h4}) begin
        miscompares++;
        $display("FAIL wait_nop[%0d] got v=%b i=%h p=%h want 0 %h 4",
                 i, Fetch_valid, Instruction_out, PCAdder_out, NOP);
      end
    end
    Imem_ready = 1'b1;
    sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
    tick();
    Imem_ready = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({Fetch_valid, Instruction_out, PCAdder_out} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL wait_deliver got v=%b i=%h p=%h want 1 %h %h",
               Fetch_valid, Instruction_out, PCAdder_out, e[63:32], e[31:0]);
    end
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_stall();
    logic [63:0] e;
    Stall = 1'b1;
    Imem_ready = 1'b1;
    tick();
    Imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({Imem_req, Fetch_valid, Instruction_out, PCAdder_out}
          !== {2'b01, mem_word(32'h4), 32'h8}) begin
        miscompares++;
        $display("FAIL stall_freeze[%0d] got req=%b v=%b i=%h p=%h want 0 1 %h 8",
                 i, Imem_req, Fetch_valid, Instruction_out, PCAdder_out,
                 mem_word(32'h4));
      end
      if (i == 0) tick();
    end
    Stall = 1'b0;
    sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
    tick();
    e = sb.pop_front();
    vectors++;
    if ({Fetch_valid, Instruction_out, PCAdder_out, Imem_req, Imem_addr}
        !== {1'b1, e, 1'b1, exp_pc + 32'd4}) begin
      miscompares++;
      $display("FAIL stall_release got v=%b i=%h p=%h req=%b a=%h want 1 %h %h 1 %h",
               Fetch_valid, Instruction_out, PCAdder_out, Imem_req, Imem_addr,
               e[63:32], e[31:0], exp_pc + 32'd4);
    end
    exp_pc = exp_pc + 32'd4;
    Imem_ready = 1'b1;
    sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
    tick();
    Imem_ready = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({Fetch_valid, Instruction_out, PCAdder_out} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL after_stall got v=%b i=%h p=%h want 1 %h %h",
               Fetch_valid, Instruction_out, PCAdder_out, e[63:32], e[31:0]);
    end
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_redirect_drop();
    tick();
    Redirect_valid = 1'b1;
    Redirect_target = 32'h40;
    tick();
    Redirect_valid = 1'b0;
    vectors++;
    if ({IFID_flush, Fetch_valid, Instruction_out, Imem_req, Imem_addr}
        !== {2'b10, NOP, 1'b1, exp_pc}) begin
      miscompares++;
      $display("FAIL drop_flush got f=%b v=%b i=%h req=%b a=%h want 1 0 %h 1 %h",
               IFID_flush, Fetch_valid, Instruction_out, Imem_req, Imem_addr,
               NOP, exp_pc);
    end
    tick();
    vectors++;
    if ({IFID_flush, Imem_addr} !== {1'b0, exp_pc}) begin
      miscompares++;
      $display("FAIL drop_hold got f=%b a=%h want 0 %h",
               IFID_flush, Imem_addr, exp_pc);
    end
    Imem_ready = 1'b1;
    tick();
    Imem_ready = 1'b0;
    exp_pc = 32'h40;
    vectors++;
    if ({Fetch_valid, Imem_req, Imem_addr} !== {2'b01, exp_pc}) begin
      miscompares++;
      $display("FAIL drop_discard got v=%b req=%b a=%h want 0 1 %h",
               Fetch_valid, Imem_req, Imem_addr, exp_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    Imem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (Imem_addr !== exp_pc) begin
        miscompares++;
        $display("FAIL b2b_addr[%0d] got %h want %h", i, Imem_addr, exp_pc);
      end
      sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
      tick();
      e = sb.pop_front();
      vectors++;
      if ({Fetch_valid, Instruction_out, PCAdder_out} !== {1'b1, e}) begin
        miscompares++;
        $display("FAIL b2b_data[%0d] got v=%b i=%h p=%h want 1 %h %h",
                 i, Fetch_valid, Instruction_out, PCAdder_out,
                 e[63:32], e[31:0]);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect_stall();
    logic [63:0] e;
    Redirect_valid = 1'b1;
    Stall = 1'b1;
    Redirect_target = 32'h103;
    tick();
    Redirect_valid = 1'b0;
    Stall = 1'b0;
    exp_pc = 32'h100;
    vectors++;
    if ({IFID_flush, Fetch_valid, Imem_req, Imem_addr}
        !== {3'b101, exp_pc}) begin
      miscompares++;
      $display("FAIL redir_stall got f=%b v=%b req=%b a=%h want 1 0 1 %h",
               IFID_flush, Fetch_valid, Imem_req, Imem_addr, exp_pc);
    end
    sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
    tick();
    e = sb.pop_front();
    vectors++;
    if ({Fetch_valid, Instruction_out, PCAdder_out, IFID_flush}
        !== {1'b1, e, 1'b0}) begin
      miscompares++;
      $display("FAIL redir_stall_data got v=%b i=%h p=%h f=%b want 1 %h %h 0",
               Fetch_valid, Instruction_out, PCAdder_out, IFID_flush,
               e[63:32], e[31:0]);
    end
    Redirect_valid = 1'b1;
    Redirect_target = 32'hFFFF_FFFF;
    tick();
    Redirect_valid = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    vectors++;
    if (Imem_addr !== exp_pc) begin
      miscompares++;
      $display("FAIL wrap_addr got %h want %h", Imem_addr, exp_pc);
    end
    sb.push_back({mem_word(exp_pc), 32'h0});
    tick();
    Imem_ready = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({Fetch_valid, Instruction_out, PCAdder_out, Imem_addr}
        !== {1'b1, e, 32'h0}) begin
      miscompares++;
      $display("FAIL wrap_data got v=%b i=%h p=%h a=%h want 1 %h %h 0",
               Fetch_valid, Instruction_out, PCAdder_out, Imem_addr,
               e[63:32], e[31:0]);
    end
    exp_pc = 32'h0;
  endtask

  task automatic test_redirect_hold();
    logic [63:0] e;
    Stall = 1'b1;
    Imem_ready = 1'b1;
    tick();
    Imem_ready = 1'b0;
    Redirect_valid = 1'b1;
    Redirect_target = 32'h500;
    tick();
    Redirect_valid = 1'b0;
    exp_pc = 32'h500;
    vectors++;
    if ({IFID_flush, Fetch_valid, Imem_req, Imem_addr}
        !== {3'b101, exp_pc}) begin
      miscompares++;
      $display("FAIL hold_redir got f=%b v=%b req=%b a=%h want 1 0 1 %h",
               IFID_flush, Fetch_valid, Imem_req, Imem_addr, exp_pc);
    end
    Stall = 1'b0;
    Imem_ready = 1'b1;
    sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
    tick();
    Imem_ready = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({Fetch_valid, Instruction_out, PCAdder_out} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL hold_discard got v=%b i=%h p=%h want 1 %h %h",
               Fetch_valid, Instruction_out, PCAdder_out, e[63:32], e[31:0]);
    end
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_drop_overwrite();
    logic [63:0] e;
    tick();
    Redirect_valid = 1'b1;
    Redirect_target = 32'h200;
    tick();
    Redirect_target = 32'h300;
    tick();
    Redirect_valid = 1'b0;
    vectors++;
    if ({Imem_addr, IFID_flush} !== {exp_pc, 1'b1}) begin
      miscompares++;
      $display("FAIL ovw_pending got a=%h f=%b want %h 1",
               Imem_addr, IFID_flush, exp_pc);
    end
    Imem_ready = 1'b1;
    tick();
    exp_pc = 32'h300;
    vectors++;
    if ({Fetch_valid, Imem_addr, IFID_flush} !== {1'b0, exp_pc, 1'b0}) begin
      miscompares++;
      $display("FAIL ovw_target got v=%b a=%h f=%b want 0 %h 0",
               Fetch_valid, Imem_addr, IFID_flush, exp_pc);
    end
    sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
    tick();
    Imem_ready = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({Fetch_valid, Instruction_out, PCAdder_out} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL ovw_data got v=%b i=%h p=%h want 1 %h %h",
               Fetch_valid, Instruction_out, PCAdder_out, e[63:32], e[31:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_stall();
    test_redirect_drop();
    test_back_to_back();
    test_redirect_stall();
    test_redirect_hold();
    test_drop_overwrite();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
